// File: rtl/clock_hms_core.sv
// 24-hour hh:mm:ss BCD time-of-day counter driven by a 1 Hz square wave,
// with button-driven hour/minute setting, field blink and a day-carry pulse.
module clock_hms_core (
    input  logic       clk,
    input  logic       reset,
    input  logic       sec_in,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [3:0] h_tens,
    output logic [3:0] h_ones,
    output logic [3:0] m_tens,
    output logic [3:0] m_ones,
    output logic [3:0] s_tens,
    output logic [3:0] s_ones,
    output logic [1:0] set_state,
    output logic       blank_h,
    output logic       blank_m,
    output logic       day_pulse
);

    typedef enum logic [1:0] {
        StRun     = 2'b00,
        StSetHour = 2'b01,
        StSetMin  = 2'b10
    } state_e;

    state_e     state_q;
    logic       sync1_q, sync2_q, sync3_q;
    logic       mode_q, inc_q;
    logic       blink_q;
    logic       blank_h_q, blank_m_q, day_pulse_q;
    logic [3:0] h_tens_q, h_ones_q, m_tens_q, m_ones_q, s_tens_q, s_ones_q;

    logic       sec_tick, mode_ev, inc_ev;
    logic       s_wrap, m_wrap, h_wrap;
    logic [3:0] h_tens_inc, h_ones_inc, m_tens_inc, m_ones_inc, s_tens_inc, s_ones_inc;

    assign sec_tick = sync2_q & ~sync3_q;
    assign mode_ev  = btn_mode & ~mode_q;
    assign inc_ev   = btn_inc & ~inc_q;

    assign s_wrap = (s_tens_q == 4'd5) && (s_ones_q == 4'd9);
    assign m_wrap = (m_tens_q == 4'd5) && (m_ones_q == 4'd9);
    assign h_wrap = (h_tens_q == 4'd2) && (h_ones_q == 4'd3);

    // Modulo increments of each field; carries between fields are applied below.
    always_comb begin
        s_ones_inc = s_ones_q + 4'd1;
        s_tens_inc = s_tens_q;
        if (s_ones_q == 4'd9) begin
            s_ones_inc = 4'd0;
            s_tens_inc = (s_tens_q == 4'd5) ? 4'd0 : s_tens_q + 4'd1;
        end

        m_ones_inc = m_ones_q + 4'd1;
        m_tens_inc = m_tens_q;
        if (m_ones_q == 4'd9) begin
            m_ones_inc = 4'd0;
            m_tens_inc = (m_tens_q == 4'd5) ? 4'd0 : m_tens_q + 4'd1;
        end

        h_ones_inc = h_ones_q + 4'd1;
        h_tens_inc = h_tens_q;
        if (h_wrap) begin
            h_ones_inc = 4'd0;
            h_tens_inc = 4'd0;
        end else if (h_ones_q == 4'd9) begin
            h_ones_inc = 4'd0;
            h_tens_inc = h_tens_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StRun;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            sync3_q     <= 1'b0;
            mode_q      <= 1'b0;
            inc_q       <= 1'b0;
            blink_q     <= 1'b0;
            blank_h_q   <= 1'b0;
            blank_m_q   <= 1'b0;
            day_pulse_q <= 1'b0;
            h_tens_q    <= 4'd0;
            h_ones_q    <= 4'd0;
            m_tens_q    <= 4'd0;
            m_ones_q    <= 4'd0;
            s_tens_q    <= 4'd0;
            s_ones_q    <= 4'd0;
        end else begin
            sync1_q     <= sec_in;
            sync2_q     <= sync1_q;
            sync3_q     <= sync2_q;
            mode_q      <= btn_mode;
            inc_q       <= btn_inc;
            day_pulse_q <= 1'b0;
            blank_h_q   <= 1'b0;
            blank_m_q   <= 1'b0;

            case (state_q)
                StRun: begin
                    blink_q <= 1'b0;
                    if (sec_tick) begin
                        s_tens_q <= s_tens_inc;
                        s_ones_q <= s_ones_inc;
                        if (s_wrap) begin
                            m_tens_q <= m_tens_inc;
                            m_ones_q <= m_ones_inc;
                        end
                        if (s_wrap && m_wrap) begin
                            h_tens_q <= h_tens_inc;
                            h_ones_q <= h_ones_inc;
                        end
                        if (s_wrap && m_wrap && h_wrap) begin
                            day_pulse_q <= 1'b1;
                        end
                    end
                    if (mode_ev) begin
                        state_q <= StSetHour;
                    end
                end

                StSetHour: begin
                    if (mode_ev) begin
                        // A mode event swallows a coincident inc event.
                        state_q <= StSetMin;
                        blink_q <= 1'b0;
                    end else begin
                        if (sec_tick) begin
                            blink_q   <= ~blink_q;
                            blank_h_q <= ~blink_q;
                        end else begin
                            blank_h_q <= blink_q;
                        end
                        if (inc_ev) begin
                            h_tens_q <= h_tens_inc;
                            h_ones_q <= h_ones_inc;
                        end
                    end
                end

                StSetMin: begin
                    if (mode_ev) begin
                        state_q  <= StRun;
                        blink_q  <= 1'b0;
                        s_tens_q <= 4'd0;
                        s_ones_q <= 4'd0;
                    end else begin
                        if (sec_tick) begin
                            blink_q   <= ~blink_q;
                            blank_m_q <= ~blink_q;
                        end else begin
                            blank_m_q <= blink_q;
                        end
                        if (inc_ev) begin
                            m_tens_q <= m_tens_inc;
                            m_ones_q <= m_ones_inc;
                        end
                    end
                end

                default: begin
                    state_q <= StRun;
                    blink_q <= 1'b0;
                end
            endcase
        end
    end

    assign h_tens    = h_tens_q;
    assign h_ones    = h_ones_q;
    assign m_tens    = m_tens_q;
    assign m_ones    = m_ones_q;
    assign s_tens    = s_tens_q;
    assign s_ones    = s_ones_q;
    assign set_state = state_q;
    assign blank_h   = blank_h_q;
    assign blank_m   = blank_m_q;
    assign day_pulse = day_pulse_q;

endmodule
